// File: rtl/color_filter_ctrl.sv
// -----------------------------------------------------------------------------
// color_filter_ctrl
//   Sequences the per-channel colour-kill controls of the pixel colour filter
//   from two push-buttons. Both buttons are synchronised and debounced, a
//   3-bit filter mode is stepped up/down (or cleared when both are pressed),
//   and the pending mode is committed to the filter outputs only on a frame
//   boundary (synchronised rising edge of vsync). This keeps every frame
//   filtered with a single, consistent setting.
//
// Parameters
//   DEBOUNCE_CYCLES : clk cycles a button level must stay stable to be accepted
//   DB_W            : debounce counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous reset, active-high
//   btn_next  in   raw async button, high = pressed, steps mode +1
//   btn_prev  in   raw async button, high = pressed, steps mode -1
//   vsync     in   raw async frame sync, high during vertical blank
//   filter_R  out  kill red   (committed mode bit 0)
//   filter_G  out  kill green (committed mode bit 1)
//   filter_B  out  kill blue  (committed mode bit 2)
//   mode      out  pending (next-frame) mode {B,G,R}
//   pending   out  mode differs from the committed filter setting
// -----------------------------------------------------------------------------
module color_filter_ctrl #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int DB_W            = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       vsync,
    output logic       filter_R,
    output logic       filter_G,
    output logic       filter_B,
    output logic [2:0] mode,
    output logic       pending
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_HELD
    } state_t;

    // Synchroniser flops
    logic r_next_s1, r_next_s2;
    logic r_prev_s1, r_prev_s2;
    logic r_vs_s1, r_vs_s2, r_vs_s3;

    // Debounce FSM state
    state_t          r_state;
    logic [DB_W-1:0] r_cnt;
    logic [1:0]      r_code;

    // Mode / committed filter registers
    logic [2:0] r_mode;
    logic [2:0] r_filt;

    logic [1:0] w_b;
    logic       w_vs_rise;

    // Next mode for a debounced button code: next = +1, prev = -1, both = clear.
    // 3-bit arithmetic gives the mod-8 wrap for free.
    function automatic logic [2:0] apply_action(input logic [1:0] code,
                                                 input logic [2:0] cur);
        logic [2:0] res;
        case (code)
            2'b10:   res = cur + 3'd1;
            2'b01:   res = cur - 3'd1;
            default: res = 3'd0;
        endcase
        return res;
    endfunction

    assign w_b       = {r_next_s2, r_prev_s2};
    assign w_vs_rise = r_vs_s2 & ~r_vs_s3;

    // Two-flop synchronisers; the third vsync flop only serves edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_next_s1 <= 1'b0;
            r_next_s2 <= 1'b0;
            r_prev_s1 <= 1'b0;
            r_prev_s2 <= 1'b0;
            r_vs_s1   <= 1'b0;
            r_vs_s2   <= 1'b0;
            r_vs_s3   <= 1'b0;
        end else begin
            r_next_s1 <= btn_next;
            r_next_s2 <= r_next_s1;
            r_prev_s1 <= btn_prev;
            r_prev_s2 <= r_prev_s1;
            r_vs_s1   <= vsync;
            r_vs_s2   <= r_vs_s1;
            r_vs_s3   <= r_vs_s2;
        end
    end

    // Debounce FSM; the mode step happens on the ARMED->HELD transition only,
    // so a long hold never auto-repeats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_code  <= 2'b00;
            r_mode  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_b != 2'b00) begin
                        r_code  <= w_b;
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_b != r_code) begin
                        // Code changed or dropped before it was stable: ignore it
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_mode  <= apply_action(r_code, r_mode);
                        r_cnt   <= '0;
                        r_state <= S_HELD;
                    end else begin
                        r_cnt <= r_cnt + DB_W'(1);
                    end
                end
                S_HELD: begin
                    // Counter now measures how long both buttons stayed released
                    if (w_b != 2'b00) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + DB_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Frame-boundary commit. If a mode step lands on the same edge, the
    // previous mode is committed and the new one waits for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt <= 3'd0;
        end else if (w_vs_rise) begin
            r_filt <= r_mode;
        end
    end

    assign mode     = r_mode;
    assign filter_R = r_filt[0];
    assign filter_G = r_filt[1];
    assign filter_B = r_filt[2];
    assign pending  = (r_mode != r_filt);

endmodule

// File: tb/tb_color_filter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_color_filter_ctrl
//   Scoreboard bench for color_filter_ctrl with DEBOUNCE_CYCLES = 4.
//   The reference model keeps timelines of (clock edge, value) for the
//   pending mode and the committed filters, derived from the behavioural
//   rules: a clean press held >= DC+1 cycles steps the mode DC+3 edges after
//   the pin rises; a vsync pin rise commits the mode seen two edges later on
//   the third edge. Expected output changes are queued when stimulus is issued
//   and a monitor pops and compares them whenever the DUT outputs change.
// -----------------------------------------------------------------------------
module tb_color_filter_ctrl;

    localparam int DC = 4;

    typedef struct {
        int         e;
        logic [2:0] v;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       btn_next;
    logic       btn_prev;
    logic       vsync;
    logic       filter_R;
    logic       filter_G;
    logic       filter_B;
    logic [2:0] mode;
    logic       pending;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    ev_t mtl[$];   // mode timeline
    ev_t ftl[$];   // committed filter timeline
    ev_t mq[$];    // expected mode changes
    ev_t fq[$];    // expected filter changes

    logic [2:0] prev_mode = 3'd0;
    logic [2:0] prev_filt = 3'd0;

    color_filter_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .DB_W(18)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .vsync(vsync),
        .filter_R(filter_R),
        .filter_G(filter_G),
        .filter_B(filter_B),
        .mode(mode),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] mode_at(input int e);
        logic [2:0] r = 3'd0;
        foreach (mtl[i]) if (mtl[i].e <= e) r = mtl[i].v;
        return r;
    endfunction

    function automatic logic [2:0] filt_at(input int e);
        logic [2:0] r = 3'd0;
        foreach (ftl[i]) if (ftl[i].e <= e) r = ftl[i].v;
        return r;
    endfunction

    // Model state restarts at zero from the current edge
    task automatic model_reset();
        ev_t z;
        mtl.delete();
        ftl.delete();
        mq.delete();
        fq.delete();
        z.e = cyc;
        z.v = 3'd0;
        mtl.push_back(z);
        ftl.push_back(z);
    endtask

    // Press a button code for len cycles, then release for gap cycles
    task automatic press(input logic [1:0] code, input int len, input int gap);
        int         s;
        logic [2:0] cur;
        logic [2:0] nv;
        ev_t        ev;
        @(posedge clk); #1;
        btn_next = code[1];
        btn_prev = code[0];
        s = cyc;
        if (len >= DC + 1) begin
            cur = mtl[$].v;
            if (code == 2'b10)      nv = cur + 3'd1;
            else if (code == 2'b01) nv = cur - 3'd1;
            else                    nv = 3'd0;
            ev.e = s + DC + 3;
            ev.v = nv;
            mtl.push_back(ev);
            if (nv != cur) mq.push_back(ev);
        end
        repeat (len) @(posedge clk);
        #1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    // vsync high for len cycles, then low for gap cycles (gap >= 2)
    task automatic vpulse(input int len, input int gap);
        int  v;
        ev_t ev;
        @(posedge clk); #1;
        vsync = 1'b1;
        v = cyc;
        ev.e = v + 3;
        ev.v = mode_at(v + 2);
        if (ev.v != ftl[$].v) fq.push_back(ev);
        ftl.push_back(ev);
        repeat (len) @(posedge clk);
        #1;
        vsync = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    // Monitor: compare on every DUT output change, plus per-cycle model state
    always begin
        ev_t e;
        @(posedge clk);
        #1;
        if (rst) begin
            prev_mode = 3'd0;
            prev_filt = 3'd0;
        end else begin
            if (mode != prev_mode) begin
                if (mq.size() == 0) begin
                    chk("mode_unexpected_change", int'(mode), int'(prev_mode));
                end else begin
                    e = mq.pop_front();
                    chk("mode_evt_val", int'(mode), int'(e.v));
                    chk("mode_evt_cyc", cyc, e.e);
                end
                prev_mode = mode;
            end
            if ({filter_B, filter_G, filter_R} != prev_filt) begin
                if (fq.size() == 0) begin
                    chk("filt_unexpected_change", int'({filter_B, filter_G, filter_R}), int'(prev_filt));
                end else begin
                    e = fq.pop_front();
                    chk("filt_evt_val", int'({filter_B, filter_G, filter_R}), int'(e.v));
                    chk("filt_evt_cyc", cyc, e.e);
                end
                prev_filt = {filter_B, filter_G, filter_R};
            end
            chk("mode_model", int'(mode), int'(mode_at(cyc)));
            chk("filt_model", int'({filter_B, filter_G, filter_R}), int'(filt_at(cyc)));
            chk("pending_model", int'(pending), int'(mode_at(cyc) != filt_at(cyc)));
        end
    end

    initial begin
        int n;
        rst      = 1'b1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        vsync    = 1'b0;
        model_reset();

        // Power-on reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mode", int'(mode), 0);
        chk("rst_filt", int'({filter_B, filter_G, filter_R}), 0);
        chk("rst_pending", int'(pending), 0);
        @(posedge clk); #3;
        rst = 1'b0;
        model_reset();

        // Glitch: 2-cycle press is ignored
        press(2'b10, 2, 8);
        #2;
        chk("glitch_mode", int'(mode), 0);

        // Long next press then frame edge: mode 1, then filter_R only
        press(2'b10, 10, 8);
        #2;
        chk("t2_mode", int'(mode), 1);
        chk("t2_pending_before", int'(pending), 1);
        vpulse(3, 4);
        #2;
        chk("t2_filt", int'({filter_B, filter_G, filter_R}), 3'b001);
        chk("t2_pending_after", int'(pending), 0);

        // Reset mid-debounce: outputs clear immediately, press discarded
        @(posedge clk); #1;
        btn_next = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_mode", int'(mode), 0);
        chk("midrst_filt", int'({filter_B, filter_G, filter_R}), 0);
        chk("midrst_pending", int'(pending), 0);
        btn_next = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("midrst_after_mode", int'(mode), 0);
        chk("midrst_after_pending", int'(pending), 0);

        // Wrap: 0 -prev-> 7 -next-> 0, 20-cycle holds give one step each
        press(2'b01, 20, 8);
        #2;
        chk("wrap_down", int'(mode), 7);
        press(2'b10, 20, 8);
        #2;
        chk("wrap_up", int'(mode), 0);

        // Both buttons clear from mode 5
        for (int i = 0; i < 5; i++) press(2'b10, 8, 7);
        vpulse(2, 4);
        #2;
        chk("t5_filt5", int'({filter_B, filter_G, filter_R}), 3'b101);
        press(2'b11, 10, 8);
        #2;
        chk("t5_mode_clear", int'(mode), 0);
        vpulse(2, 4);
        #2;
        chk("t5_filt_clear", int'({filter_B, filter_G, filter_R}), 3'b000);

        // Action and frame edge on the same cycle, mode 2 -> 3
        press(2'b10, 8, 7);
        press(2'b10, 8, 7);
        vpulse(2, 4);
        fork
            press(2'b10, 10, 8);
            begin
                repeat (DC) @(posedge clk);
                vpulse(2, 4);
            end
        join
        #2;
        chk("t6_filt_old", int'({filter_B, filter_G, filter_R}), 3'b010);
        chk("t6_mode_new", int'(mode), 3);
        vpulse(2, 4);
        #2;
        chk("t6_filt_next", int'({filter_B, filter_G, filter_R}), 3'b011);

        // Randomised presses, glitches and frame edges
        for (int i = 0; i < 40; i++) begin
            n = int'($urandom_range(0, 3));
            if (n == 0) begin
                vpulse(int'($urandom_range(1, 6)), int'($urandom_range(2, 8)));
            end else begin
                logic [1:0] code;
                code = (n == 1) ? 2'b10 : (n == 2) ? 2'b01 : 2'b11;
                if ($urandom_range(0, 3) == 0)
                    press(code, int'($urandom_range(1, DC)), int'($urandom_range(DC + 2, 10)));
                else
                    press(code, int'($urandom_range(DC + 1, 16)), int'($urandom_range(DC + 2, 10)));
            end
        end
        vpulse(2, 4);

        // All queued events must have been observed
        n = 0;
        while ((mq.size() != 0 || fq.size() != 0) && n < 100) begin
            @(posedge clk);
            n = n + 1;
        end
        #2;
        chk("mode_queue_drained", mq.size(), 0);
        chk("filt_queue_drained", fq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
